// File: rtl/ov7670_fifo_reader.sv
// Reads one frame out of the AL422B frame FIFO behind the OV7670 and streams it
// into the TX cache FIFO as OUT_W-bit big-endian words, with back-pressure and abort.
module ov7670_fifo_reader #(
    parameter int unsigned H_PIX         = 320,
    parameter int unsigned V_LINES       = 240,
    parameter int unsigned BYTES_PER_PIX = 2,
    parameter int unsigned OUT_W         = 16,
    parameter int unsigned RCLK_HALF     = 1,
    parameter int unsigned RRST_CYC      = 3
) (
    input  logic             CLK_40M,
    input  logic             RST_N,
    input  logic             READ_EN,
    input  logic             ABORT,
    input  logic [7:0]       OV_DATA,
    input  logic             TX_CACHE_WRFULL,
    output logic             OV_RRST,
    output logic             OV_RCLK,
    output logic [OUT_W-1:0] TX_CACHE_DATA,
    output logic             TX_CACHE_WRREQ,
    output logic             RD_FRAME,
    output logic             FRAME_DONE,
    output logic [31:0]      WORD_CNT
);

    localparam int unsigned NBYTES = H_PIX * V_LINES * BYTES_PER_PIX;
    localparam int unsigned BPW    = OUT_W / 8;
    localparam int unsigned NWORDS = NBYTES / BPW;
    localparam int unsigned HCW    = (RCLK_HALF > 1) ? $clog2(RCLK_HALF) : 1;
    localparam int unsigned SCW    = (RRST_CYC > 1) ? $clog2(RRST_CYC) : 1;
    localparam int unsigned BCW    = $clog2(NBYTES + 1);
    localparam int unsigned BIW    = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [HCW-1:0] HALF_LAST = HCW'(RCLK_HALF - 1);
    localparam logic [SCW-1:0] SLOT_LAST = SCW'(RRST_CYC - 1);
    localparam logic [BIW-1:0] BIDX_LAST = BIW'(BPW - 1);
    localparam logic [BCW-1:0] BCNT_LAST = BCW'(NBYTES - 1);
    localparam logic [BCW-1:0] BCNT_ALL  = BCW'(NBYTES);
    localparam logic [31:0]    WC_LAST   = 32'(NWORDS - 1);
    localparam logic [31:0]    WC_MAX    = 32'(NWORDS);

    typedef enum logic [1:0] {StIdle, StRrst, StGap, StRead} state_e;

    state_e           state;
    logic [HCW-1:0]   half_cnt;
    logic [SCW-1:0]   slot_cnt;
    logic [BCW-1:0]   byte_cnt;
    logic [BIW-1:0]   byte_idx;
    logic             in_slot;
    logic             pending;
    // Assembles the current word and doubles as the held word while the cache is full.
    logic [OUT_W-1:0] asm_word;

    logic [OUT_W-1:0] word_next;
    logic [OUT_W-1:0] wr_word;
    logic             half_end;
    logic             word_end;
    logic             last_byte;
    logic             last_word;
    logic             capture;
    logic             do_write;

    if (OUT_W > 8) begin : g_wide
        assign word_next = {asm_word[OUT_W-9:0], OV_DATA};
    end else begin : g_narrow
        assign word_next = OV_DATA;
    end

    always_comb begin
        half_end  = (half_cnt == HALF_LAST);
        word_end  = (byte_idx == BIDX_LAST);
        last_byte = (byte_cnt == BCNT_LAST);
        last_word = (WORD_CNT == WC_LAST);
        capture   = (state == StRead) && !pending && in_slot && OV_RCLK && half_end;
        do_write  = (state == StRead) && !TX_CACHE_WRFULL && (pending || (capture && word_end));
        wr_word   = pending ? asm_word : word_next;
    end

    always_ff @(posedge CLK_40M or negedge RST_N) begin
        if (!RST_N) begin
            state          <= StIdle;
            OV_RRST        <= 1'b1;
            OV_RCLK        <= 1'b1;
            TX_CACHE_DATA  <= '0;
            TX_CACHE_WRREQ <= 1'b0;
            RD_FRAME       <= 1'b1;
            FRAME_DONE     <= 1'b0;
            WORD_CNT       <= '0;
            half_cnt       <= '0;
            slot_cnt       <= '0;
            byte_cnt       <= '0;
            byte_idx       <= '0;
            in_slot        <= 1'b0;
            pending        <= 1'b0;
            asm_word       <= '0;
        end else begin
            TX_CACHE_WRREQ <= 1'b0;
            FRAME_DONE     <= 1'b0;
            if (ABORT && (state != StIdle)) begin
                state    <= StIdle;
                OV_RCLK  <= 1'b1;
                OV_RRST  <= 1'b1;
                RD_FRAME <= 1'b1;
                in_slot  <= 1'b0;
                pending  <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        OV_RCLK  <= 1'b1;
                        RD_FRAME <= 1'b1;
                        if (READ_EN && !ABORT) begin
                            state    <= StRrst;
                            RD_FRAME <= 1'b0;
                            WORD_CNT <= '0;
                            OV_RRST  <= 1'b0;
                            OV_RCLK  <= 1'b0;
                            half_cnt <= '0;
                            slot_cnt <= '0;
                            byte_cnt <= '0;
                            byte_idx <= '0;
                            in_slot  <= 1'b0;
                            pending  <= 1'b0;
                        end
                    end
                    StRrst: begin
                        if (!half_end) begin
                            half_cnt <= half_cnt + 1'b1;
                        end else begin
                            half_cnt <= '0;
                            if (!OV_RCLK) begin
                                OV_RCLK <= 1'b1;
                            end else if (slot_cnt == SLOT_LAST) begin
                                OV_RRST <= 1'b1;
                                state   <= StGap;
                            end else begin
                                slot_cnt <= slot_cnt + 1'b1;
                                OV_RCLK  <= 1'b0;
                            end
                        end
                    end
                    StGap: begin
                        state    <= StRead;
                        in_slot  <= 1'b1;
                        OV_RCLK  <= 1'b0;
                        half_cnt <= '0;
                    end
                    StRead: begin
                        if (pending) begin
                            if (!TX_CACHE_WRFULL) pending <= 1'b0;
                        end else if (in_slot) begin
                            if (!half_end) begin
                                half_cnt <= half_cnt + 1'b1;
                            end else begin
                                half_cnt <= '0;
                                if (!OV_RCLK) begin
                                    OV_RCLK <= 1'b1;
                                end else begin
                                    asm_word <= word_next;
                                    byte_cnt <= byte_cnt + 1'b1;
                                    if (word_end) begin
                                        byte_idx <= '0;
                                        if (TX_CACHE_WRFULL) pending <= 1'b1;
                                    end else begin
                                        byte_idx <= byte_idx + 1'b1;
                                    end
                                    // Keep RCLK high between slots when the frame is
                                    // finished or a word is stuck behind a full cache.
                                    if (last_byte || (word_end && TX_CACHE_WRFULL)) begin
                                        in_slot <= 1'b0;
                                    end else begin
                                        OV_RCLK <= 1'b0;
                                    end
                                end
                            end
                        end else if (byte_cnt == BCNT_ALL) begin
                            state    <= StIdle;
                            RD_FRAME <= 1'b1;
                        end else begin
                            in_slot  <= 1'b1;
                            OV_RCLK  <= 1'b0;
                            half_cnt <= '0;
                        end
                    end
                    default: state <= StIdle;
                endcase

                if (do_write) begin
                    TX_CACHE_DATA  <= wr_word;
                    TX_CACHE_WRREQ <= 1'b1;
                    FRAME_DONE     <= last_word;
                    if (WORD_CNT != WC_MAX) WORD_CNT <= WORD_CNT + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_fifo_reader.sv
// Bench for ov7670_fifo_reader: AL422B read-side model, word scoreboard, directed frames
// on a 16-bit/RCLK_HALF=1 instance and an 8-bit/RCLK_HALF=2 instance.
module tb_ov7670_fifo_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- instance A: 16-bit words, RCLK_HALF=1 ----------------
    logic        read_en_a = 1'b0, abort_a = 1'b0, wrfull_a = 1'b0;
    logic [7:0]  ov_data_a;
    logic        ov_rrst_a, ov_rclk_a, wrreq_a, rd_frame_a, frame_done_a;
    logic [15:0] data_a;
    logic [31:0] word_cnt_a;

    ov7670_fifo_reader #(
        .H_PIX(4), .V_LINES(2), .BYTES_PER_PIX(2), .OUT_W(16), .RCLK_HALF(1), .RRST_CYC(3)
    ) u_dut_a (
        .CLK_40M(clk), .RST_N(rst_n), .READ_EN(read_en_a), .ABORT(abort_a),
        .OV_DATA(ov_data_a), .TX_CACHE_WRFULL(wrfull_a), .OV_RRST(ov_rrst_a),
        .OV_RCLK(ov_rclk_a), .TX_CACHE_DATA(data_a), .TX_CACHE_WRREQ(wrreq_a),
        .RD_FRAME(rd_frame_a), .FRAME_DONE(frame_done_a), .WORD_CNT(word_cnt_a)
    );

    // ---------------- instance B: 8-bit words, RCLK_HALF=2 ----------------
    logic        read_en_b = 1'b0, abort_b = 1'b0, wrfull_b = 1'b0;
    logic [7:0]  ov_data_b;
    logic        ov_rrst_b, ov_rclk_b, wrreq_b, rd_frame_b, frame_done_b;
    logic [7:0]  data_b;
    logic [31:0] word_cnt_b;

    ov7670_fifo_reader #(
        .H_PIX(4), .V_LINES(2), .BYTES_PER_PIX(2), .OUT_W(8), .RCLK_HALF(2), .RRST_CYC(3)
    ) u_dut_b (
        .CLK_40M(clk), .RST_N(rst_n), .READ_EN(read_en_b), .ABORT(abort_b),
        .OV_DATA(ov_data_b), .TX_CACHE_WRFULL(wrfull_b), .OV_RRST(ov_rrst_b),
        .OV_RCLK(ov_rclk_b), .TX_CACHE_DATA(data_b), .TX_CACHE_WRREQ(wrreq_b),
        .RD_FRAME(rd_frame_b), .FRAME_DONE(frame_done_b), .WORD_CNT(word_cnt_b)
    );

    // AL422B read side: pointer clears on RCLK rises under RRST, else next byte appears.
    logic [7:0] base_a = 8'h00, base_b = 8'h00;
    int ptr_a = 0, ptr_b = 0;
    always @(posedge ov_rclk_a) begin
        if (ov_rrst_a === 1'b0) ptr_a <= 0;
        else begin
            ov_data_a <= base_a + 8'(ptr_a);
            ptr_a     <= ptr_a + 1;
        end
    end
    always @(posedge ov_rclk_b) begin
        if (ov_rrst_b === 1'b0) ptr_b <= 0;
        else begin
            ov_data_b <= base_b + 8'(ptr_b);
            ptr_b     <= ptr_b + 1;
        end
    end

    // Monitors and scoreboards.
    logic [15:0] q_a[$];
    logic [7:0]  q_b[$];
    int wr_a = 0, fd_a = 0, rl_a = 0, rr_a = 0, rd_a = 0;
    int wr_b = 0, fd_b = 0, rl_b = 0, rr_b = 0, rd_b = 0, bad_b = 0, last_rise_b = 0;
    logic prev_a = 1'b1, prev_b = 1'b1, seen_b = 1'b0;

    always @(negedge clk) begin
        logic [15:0] exp_w;
        if (wrreq_a) begin
            wr_a <= wr_a + 1;
            exp_w = (q_a.size() != 0) ? q_a.pop_front() : 16'hxxxx;
            check("a_wr_data", data_a, exp_w);
        end
        if (frame_done_a) begin
            fd_a <= fd_a + 1;
            check("a_fd_with_wr", wrreq_a, 1'b1);
            check("a_fd_last_word", q_a.size(), 0);
        end
        if (ov_rclk_a && !prev_a) begin
            if (!ov_rrst_a) rr_a <= rr_a + 1;
            else rd_a <= rd_a + 1;
        end
        if (!ov_rrst_a) rl_a <= rl_a + 1;
        prev_a <= ov_rclk_a;
    end

    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (wrreq_b) begin
            wr_b <= wr_b + 1;
            exp_b = (q_b.size() != 0) ? q_b.pop_front() : 8'hxx;
            check("b_wr_data", data_b, exp_b);
        end
        if (frame_done_b) fd_b <= fd_b + 1;
        if (ov_rclk_b && !prev_b) begin
            if (!ov_rrst_b) rr_b <= rr_b + 1;
            else begin
                rd_b <= rd_b + 1;
                if (seen_b && (cyc - last_rise_b != 4)) bad_b <= bad_b + 1;
                seen_b      <= 1'b1;
                last_rise_b <= cyc;
            end
        end
        if (!ov_rrst_b) rl_b <= rl_b + 1;
        prev_b <= ov_rclk_b;
    end

    localparam logic [52:0] RST_VEC_A = {1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 32'd0};
    localparam logic [44:0] RST_VEC_B = {1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'd0};

    int s_wr, s_fd, s_rl, s_rr, s_rd;

    task automatic snap_a();
        s_wr = wr_a; s_fd = fd_a; s_rl = rl_a; s_rr = rr_a; s_rd = rd_a;
    endtask

    task automatic push_a(input logic [7:0] base, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            q_a.push_back({base + 8'(2 * w), base + 8'(2 * w + 1)});
        end
    endtask

    task automatic start_a(input string tag);
        @(negedge clk);
        read_en_a = 1'b1;
        @(negedge clk);
        read_en_a = 1'b0;
        #1;
        check({tag, "_busy"}, rd_frame_a, 1'b0);
    endtask

    task automatic wait_idle_a(input string tag);
        for (int i = 0; i < 400 && rd_frame_a !== 1'b1; i++) @(negedge clk);
        #1;
        check({tag, "_done_in_time"}, rd_frame_a, 1'b1);
    endtask

    task automatic wait_wr_a(input string tag, input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (wr_a - s_wr >= n) break;
        end
        check({tag, "_wr_reached"}, wr_a - s_wr, n);
    endtask

    task automatic check_frame_a(input string tag);
        check({tag, "_wrreq_count"}, wr_a - s_wr, 8);
        check({tag, "_frame_done_count"}, fd_a - s_fd, 1);
        check({tag, "_word_cnt"}, word_cnt_a, 8);
        check({tag, "_queue_empty"}, q_a.size(), 0);
        check({tag, "_rrst_low_cycles"}, rl_a - s_rl, 6);
        check({tag, "_rrst_rises"}, rr_a - s_rr, 3);
        check({tag, "_read_rises"}, rd_a - s_rd, 16);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("a_reset", {ov_rrst_a, ov_rclk_a, data_a, wrreq_a, rd_frame_a, frame_done_a,
                          word_cnt_a}, RST_VEC_A);
        check("b_reset", {ov_rrst_b, ov_rclk_b, data_b, wrreq_b, rd_frame_b, frame_done_b,
                          word_cnt_b}, RST_VEC_B);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Plain frame, bytes 0x00..0x0F.
        base_a = 8'h00; push_a(8'h00, 8); snap_a();
        start_a("f1");
        wait_idle_a("f1");
        check_frame_a("f1");

        // Cache full for 20 cycles after word 3.
        base_a = 8'h20; push_a(8'h20, 8); snap_a();
        start_a("f2");
        wait_wr_a("f2", 3);
        wrfull_a = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("f2_bp_rises_frozen", rd_a - s_rd, 8);
        check("f2_bp_rclk_high", ov_rclk_a, 1'b1);
        check("f2_bp_word_held", wr_a - s_wr, 3);
        check("f2_bp_word_cnt", word_cnt_a, 3);
        wrfull_a = 1'b0;
        wait_idle_a("f2");
        check_frame_a("f2");

        // Abort after word 5.
        base_a = 8'h40; push_a(8'h40, 5); snap_a();
        start_a("f3");
        wait_wr_a("f3", 5);
        abort_a = 1'b1;
        @(negedge clk);
        #1;
        abort_a = 1'b0;
        check("f3_abort_rd_frame", rd_frame_a, 1'b1);
        check("f3_abort_rclk", ov_rclk_a, 1'b1);
        check("f3_abort_rrst", ov_rrst_a, 1'b1);
        check("f3_abort_word_cnt", word_cnt_a, 5);
        repeat (30) @(negedge clk);
        #1;
        check("f3_no_more_wr", wr_a - s_wr, 5);
        check("f3_no_frame_done", fd_a - s_fd, 0);
        check("f3_word_cnt_holds", word_cnt_a, 5);

        // ABORT with READ_EN in idle: stays idle.
        abort_a = 1'b1; read_en_a = 1'b1;
        @(negedge clk);
        #1;
        check("idle_abort_wins_rd_frame", rd_frame_a, 1'b1);
        check("idle_abort_wins_rrst", ov_rrst_a, 1'b1);
        check("idle_abort_wins_word_cnt", word_cnt_a, 5);
        abort_a = 1'b0; read_en_a = 1'b0;
        repeat (2) @(negedge clk);

        // Restart after abort.
        base_a = 8'h60; push_a(8'h60, 8); snap_a();
        start_a("f4");
        wait_idle_a("f4");
        check_frame_a("f4");

        // Async reset in the middle of READ.
        base_a = 8'h80; push_a(8'h80, 8); snap_a();
        start_a("f5");
        wait_wr_a("f5", 2);
        rst_n = 1'b0;
        #1;
        check("f5_async_reset", {ov_rrst_a, ov_rclk_a, data_a, wrreq_a, rd_frame_a,
                                 frame_done_a, word_cnt_a}, RST_VEC_A);
        q_a.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Instance B: byte-wide words, RCLK period of four cycles.
        base_b = 8'hA0;
        for (int i = 0; i < 16; i++) q_b.push_back(8'hA0 + 8'(i));
        @(negedge clk);
        read_en_b = 1'b1;
        @(negedge clk);
        read_en_b = 1'b0;
        #1;
        check("b_busy", rd_frame_b, 1'b0);
        for (int i = 0; i < 600 && rd_frame_b !== 1'b1; i++) @(negedge clk);
        #1;
        check("b_done_in_time", rd_frame_b, 1'b1);
        check("b_wrreq_count", wr_b, 16);
        check("b_frame_done_count", fd_b, 1);
        check("b_word_cnt", word_cnt_b, 16);
        check("b_queue_empty", q_b.size(), 0);
        check("b_rrst_low_cycles", rl_b, 12);
        check("b_rrst_rises", rr_b, 3);
        check("b_read_rises", rd_b, 16);
        check("b_rclk_period_errors", bad_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
